cnn_layer_sequencer: RTL and testbench
======================================

Name: cnn_layer_sequencer

Overview:
- Parametrised control sequencer for the quickdraw CNN pipeline. It replaces the fixed six-layer top-level control FSM and its ten-way combinational argmax.
- Launches NUM_LAYERS layer engines in order using a level start/done handshake. Supervises each layer with a watchdog and supports abort.
- After the last layer, consumes the final layer's class scores as a valid/ready stream and resolves the predicted class with a sequential argmax.

Parameters:
- NUM_LAYERS, 6, number of sequenced layer engines (>=1).
- NUM_CLASSES, 10, number of class scores streamed after the last layer (>=2).
- SCORE_W, 32, signed score width.
- TIMEOUT_CYCLES, 1000000, max cycles a layer may stay active; 0 disables the watchdog.
- CLS_W, $clog2(NUM_CLASSES), class index width (derived, not overridden).

Ports:
- clk  in  1  clock
- reset  in  1  reset
- start  in  1  run request, level
- abort  in  1  synchronous abort, level
- layer_start  out  NUM_LAYERS  one-hot; bit i is high while layer i is active
- layer_done  in  NUM_LAYERS  done from each layer engine
- score_valid  in  1  score stream valid
- score_data  in  SCORE_W  signed score, class order 0..NUM_CLASSES-1
- score_ready  out  1  score stream ready
- busy  out  1  high in every state except IDLE, FINISHED, ERROR
- done  out  1  result valid
- error  out  1  watchdog fired
- err_layer  out  $clog2(NUM_LAYERS)+1  index of the timed-out layer
- predicted_class  out  CLS_W  argmax index
- max_score  out  SCORE_W  winning score
- cycle_count  out  32  cycles from start acceptance to done, saturating

Behaviour:
- Interface: reset is reset, asynchronous, active-high; clock is clk.
- Reset: all outputs 0; state IDLE; layer index 0.
- States: IDLE, RUN, GAP, SCAN, FINISHED, ERROR.
- IDLE -> RUN when start=1. Clear layer index, watchdog, cycle_count, done, error and argmax registers.
- RUN:
  - layer_start[idx]=1; all other bits 0.
  - layer_done[idx] is sampled every RUN cycle, including the first.
  - layer_done bits for inactive layers are ignored.
  - On layer_done[idx]=1: if idx==NUM_LAYERS-1 -> SCAN, else -> GAP with idx+1.
- GAP: exactly one cycle with layer_start all-zero, so each engine sees start drop. Then -> RUN.
- Watchdog:
  - Counts RUN cycles of the current layer.
  - If the count reaches TIMEOUT_CYCLES with no done -> ERROR, err_layer=idx.
  - If done and timeout occur in the same cycle, done wins.
- SCAN:
  - score_ready=1; a beat is accepted when score_valid & score_ready.
  - Beat 0 loads max_score and predicted_class=0.
  - A later beat k replaces the result only if score_data > max_score (signed, strict). Ties keep the lowest index.
  - After beat NUM_CLASSES-1 is accepted -> FINISHED. done=1 in the next cycle; score_ready drops in the same cycle.
  - Idle-valid cycles are allowed with no limit; there is no watchdog in SCAN.
- FINISHED:
  - done=1 and results held stable.
  - When start=0 -> IDLE; done clears and results are held until the next start acceptance.
- ERROR: error=1, layer_start all-zero. When start=0 -> IDLE.
- Abort:
  - In RUN, GAP or SCAN: next cycle -> IDLE with layer_start all-zero, score_ready=0, done=0, error=0.
  - Partial argmax is discarded.
  - Abort overrides done and timeout in the same cycle.
  - Abort is ignored in IDLE, FINISHED and ERROR.
- cycle_count increments in RUN, GAP and SCAN, saturates at 2^32-1, and freezes on FINISHED or ERROR.
- start held high in IDLE after returning from FINISHED does not relaunch; start must be seen low first, because FINISHED only exits on start=0.

Test Plan:
- Nominal, defaults. Layer models raise done 3 cycles after start rises. Scores {5,-2,9,9,0,1,-7,3,8,4}, always valid. -> predicted_class=2, max_score=9, done=1, layer_start sequence 1,2,4,8,16,32 with one all-zero gap between layers, cycle_count=6*3+5+10 (+/-1 per documented edge).
- All-negative scores {-10,-3,-3,-50,...,-9}, valid toggling every other cycle. -> predicted_class=1, max_score=-3; score_ready stays high until the 10th accepted beat.
- TIMEOUT_CYCLES=16, layer 3 never raises done. -> error=1 and err_layer=3 on cycle 16 of layer 3; busy=0; start low -> IDLE, error=0.
- Abort asserted mid-SCAN after 4 beats. -> IDLE next cycle, done=0, score_ready=0; a fresh start then yields the correct argmax of a new vector.
- layer_done[5] held high during layer 0, and layer_done[2] rises in the same cycle as the watchdog expires for layer 2. -> stray done ignored; layer 2 completes with no error.
- Reset asserted asynchronously during RUN of layer 4. -> all outputs 0 immediately; start afterwards restarts at layer 0.

Source files
------------

// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: launches NUM_LAYERS layer engines in order with a level
// start/done handshake, supervises each layer with a watchdog, then streams the
// final class scores in and resolves the predicted class with a sequential argmax.
//
// Score stream handshake: a beat transfers on a rising clk edge where
// score_valid and score_ready are both high. score_ready is high exactly while
// the sequencer is in SCAN. score_valid may stay low for any number of cycles.
module cnn_layer_sequencer #(
  parameter int NUM_LAYERS     = 6,
  parameter int NUM_CLASSES    = 10,
  parameter int SCORE_W        = 32,
  parameter int TIMEOUT_CYCLES = 1000000,
  localparam int CLS_W         = $clog2(NUM_CLASSES),
  localparam int LYR_W         = $clog2(NUM_LAYERS) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic [NUM_LAYERS-1:0] layer_start,
  input  logic [NUM_LAYERS-1:0] layer_done,
  input  logic                  score_valid,
  input  logic [SCORE_W-1:0]    score_data,
  output logic                  score_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [LYR_W-1:0]      err_layer,
  output logic [CLS_W-1:0]      predicted_class,
  output logic [SCORE_W-1:0]    max_score,
  output logic [31:0]           cycle_count,
  output logic [2:0]            dbg_state
);

  localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [31:0] TIMEOUT_L = 32'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    GAP      = 3'd2,
    SCAN     = 3'd3,
    FINISHED = 3'd4,
    ERROR    = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [LYR_W-1:0]     idx_q, idx_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [31:0]          cyc_q, cyc_d;
  logic [CLS_W-1:0]     beat_q, beat_d;
  logic [SCORE_W-1:0]   max_q, max_d;
  logic [CLS_W-1:0]     cls_q, cls_d;
  logic [LYR_W-1:0]     err_layer_q, err_layer_d;

  logic [NUM_LAYERS-1:0] layer_sel;
  logic                  done_cur;
  logic                  wd_hit;
  logic                  active;

  // Only the done bit of the currently active layer matters; others are masked.
  assign layer_sel = NUM_LAYERS'(1) << idx_q;
  assign done_cur  = |(layer_done & layer_sel);
  // Current RUN cycle is number wd_q+1 of this layer; expiry when it reaches the limit.
  assign wd_hit    = (TIMEOUT_CYCLES != 0) && ((32'(wd_q) + 32'd1) >= TIMEOUT_L);
  assign active    = (state_q == RUN) || (state_q == GAP) || (state_q == SCAN);

  // Next-state, watchdog, cycle counter and argmax update.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wd_d        = wd_q;
    cyc_d       = cyc_q;
    beat_d      = beat_q;
    max_d       = max_q;
    cls_d       = cls_q;
    err_layer_d = err_layer_q;

    if (active && (cyc_q != 32'hFFFF_FFFF)) cyc_d = cyc_q + 32'd1;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          idx_d       = '0;
          wd_d        = '0;
          cyc_d       = '0;
          beat_d      = '0;
          max_d       = '0;
          cls_d       = '0;
          err_layer_d = '0;
        end
      end
      RUN: begin
        if (done_cur) begin
          wd_d = '0;
          if (idx_q == LYR_W'(NUM_LAYERS - 1)) begin
            state_d = SCAN;
          end else begin
            state_d = GAP;
            idx_d   = idx_q + LYR_W'(1);
          end
        end else if (wd_hit) begin
          state_d     = ERROR;
          err_layer_d = idx_q;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      GAP: state_d = RUN;
      SCAN: begin
        if (score_valid) begin
          beat_d = beat_q + CLS_W'(1);
          // Strict compare keeps the lowest index on ties.
          if ((beat_q == '0) || ($signed(score_data) > $signed(max_q))) begin
            max_d = score_data;
            cls_d = beat_q;
          end
          if (beat_q == CLS_W'(NUM_CLASSES - 1)) state_d = FINISHED;
        end
      end
      FINISHED: if (!start) state_d = IDLE;
      ERROR:    if (!start) state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    // Abort beats done and timeout; any partial argmax is thrown away.
    if (abort && active) begin
      state_d = IDLE;
      wd_d    = '0;
      beat_d  = '0;
      max_d   = '0;
      cls_d   = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      wd_q        <= '0;
      cyc_q       <= '0;
      beat_q      <= '0;
      max_q       <= '0;
      cls_q       <= '0;
      err_layer_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wd_q        <= wd_d;
      cyc_q       <= cyc_d;
      beat_q      <= beat_d;
      max_q       <= max_d;
      cls_q       <= cls_d;
      err_layer_q <= err_layer_d;
    end
  end

  assign layer_start     = (state_q == RUN) ? layer_sel : '0;
  assign score_ready     = (state_q == SCAN);
  assign busy            = active;
  assign done            = (state_q == FINISHED);
  assign error           = (state_q == ERROR);
  assign err_layer       = err_layer_q;
  assign predicted_class = cls_q;
  assign max_score       = max_q;
  assign cycle_count     = cyc_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench for cnn_layer_sequencer: layer engine models, score source,
// layer_start trace scoreboard and hand-computed expectations.
module tb_cnn_layer_sequencer;
  localparam int NL = 6;
  localparam int NC = 10;
  localparam int SW = 32;
  localparam int TO = 16;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          start, abort;
  logic [NL-1:0] layer_start;
  logic [NL-1:0] layer_done = '0;
  logic          score_valid = 1'b0;
  logic [SW-1:0] score_data = '0;
  logic          score_ready, busy, done, error;
  logic [3:0]    err_layer;
  logic [3:0]    predicted_class;
  logic [SW-1:0] max_score;
  logic [31:0]   cycle_count;
  logic [2:0]    dbg_state;

  cnn_layer_sequencer #(
    .NUM_LAYERS(NL), .NUM_CLASSES(NC), .SCORE_W(SW), .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .layer_start(layer_start), .layer_done(layer_done),
    .score_valid(score_valid), .score_data(score_data), .score_ready(score_ready),
    .busy(busy), .done(done), .error(error), .err_layer(err_layer),
    .predicted_class(predicted_class), .max_score(max_score),
    .cycle_count(cycle_count), .dbg_state(dbg_state)
  );

  // Environment configuration
  int                dly [NL];
  bit                stray5 = 1'b0;
  bit                tog_mode = 1'b0;
  logic signed [31:0] scores [NC];
  int                beat_acc = 0;
  bit                rdy_prev = 1'b0;
  int                run_cnt = 0;
  bit                tog = 1'b0;
  logic [NL-1:0]     trace_q [$];
  logic [NL-1:0]     last_ls = '0;
  logic [NL-1:0]     exp_q [$];

  int n_cmp = 0;
  int n_err = 0;

  // Layer engine models, score source and layer_start trace, all on the falling edge.
  always @(negedge clk) begin
    if (score_valid && rdy_prev) beat_acc++;
    rdy_prev = score_ready;
    if (layer_start == '0) run_cnt = 0;
    else run_cnt++;
    for (int i = 0; i < NL; i++)
      layer_done[i] = layer_start[i] && (dly[i] != 0) && (run_cnt >= dly[i]);
    if (stray5 && layer_start[0]) layer_done[5] = 1'b1;
    tog = ~tog;
    if (score_ready && (beat_acc < NC)) begin
      score_valid = tog_mode ? tog : 1'b1;
      score_data  = scores[beat_acc];
    end else begin
      score_valid = 1'b0;
    end
    if (layer_start != last_ls) trace_q.push_back(layer_start);
    last_ls = layer_start;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic start_run();
    beat_acc = 0;
    start = 1'b1;
  endtask

  task automatic wait_end(input string tag, input int bound);
    int i;
    i = 0;
    while (!(done || error) && i < bound) begin
      tick(1);
      i++;
    end
    check_eq({tag, "_bound"}, 32'(done || error), 32'd1);
  endtask

  task automatic set_dly(input int d);
    for (int i = 0; i < NL; i++) dly[i] = d;
  endtask

  initial begin
    int n;
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b1;
    set_dly(3);
    scores = '{5, -2, 9, 9, 0, 1, -7, 3, 8, 4};
    tick(2);
    reset = 1'b0;
    tick(1);
    check_eq("rst_layer_start", 32'(layer_start), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_error", 32'(error), 32'd0);
    check_eq("rst_ready", 32'(score_ready), 32'd0);
    check_eq("rst_cycles", cycle_count, 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'd0);

    // Nominal run: 3-cycle layers, always-valid scores.
    trace_q.delete();
    last_ls = '0;
    start_run();
    wait_end("nom", 200);
    check_eq("nom_done", 32'(done), 32'd1);
    check_eq("nom_error", 32'(error), 32'd0);
    check_eq("nom_class", 32'(predicted_class), 32'd2);
    check_eq("nom_max", max_score, 32'd9);
    check_eq("nom_cycles", cycle_count, 32'd33);
    check_eq("nom_busy", 32'(busy), 32'd0);
    check_eq("nom_ready", 32'(score_ready), 32'd0);
    exp_q = '{6'd1, 6'd0, 6'd2, 6'd0, 6'd4, 6'd0, 6'd8, 6'd0, 6'd16, 6'd0, 6'd32, 6'd0};
    check_eq("nom_trace_len", 32'(trace_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && trace_q.size() > 0)
      check_eq("nom_trace", 32'(trace_q.pop_front()), 32'(exp_q.pop_front()));
    // start still high: must stay FINISHED with stable results.
    tick(3);
    check_eq("hold_done", 32'(done), 32'd1);
    check_eq("hold_cycles", cycle_count, 32'd33);
    start = 1'b0;
    tick(1);
    check_eq("idle_done", 32'(done), 32'd0);
    check_eq("idle_class_held", 32'(predicted_class), 32'd2);
    check_eq("idle_state", 32'(dbg_state), 32'd0);

    // All-negative scores with valid toggling.
    tog_mode = 1'b1;
    scores = '{-10, -3, -3, -50, -20, -7, -4, -60, -8, -9};
    start_run();
    n = 0;
    while (!score_ready && n < 100) begin tick(1); n++; end
    check_eq("neg_ready_bound", 32'(score_ready), 32'd1);
    n = 0;
    while (score_ready && n < 100) begin tick(1); n++; end
    check_eq("neg_beats_at_drop", 32'(beat_acc), 32'd10);
    check_eq("neg_done", 32'(done), 32'd1);
    check_eq("neg_class", 32'(predicted_class), 32'd1);
    check_eq("neg_max", max_score, 32'(-3));
    start = 1'b0;
    tog_mode = 1'b0;
    tick(1);

    // Watchdog: layer 3 never finishes.
    dly[3] = 0;
    start_run();
    n = 0;
    while (layer_start != 6'd8 && n < 100) begin tick(1); n++; end
    n = 0;
    while (layer_start == 6'd8 && n < 100) begin tick(1); n++; end
    check_eq("wd_run_cycles", 32'(n), 32'd16);
    check_eq("wd_error", 32'(error), 32'd1);
    check_eq("wd_err_layer", 32'(err_layer), 32'd3);
    check_eq("wd_busy", 32'(busy), 32'd0);
    check_eq("wd_layer_start", 32'(layer_start), 32'd0);
    start = 1'b0;
    tick(1);
    check_eq("wd_clear", 32'(error), 32'd0);
    check_eq("wd_idle", 32'(dbg_state), 32'd0);
    dly[3] = 3;

    // Abort after 4 accepted beats, then a fresh run.
    scores = '{5, -2, 9, 9, 0, 1, -7, 3, 8, 4};
    start_run();
    n = 0;
    while (beat_acc < 4 && n < 200) begin tick(1); n++; end
    check_eq("abort_beats", 32'(beat_acc), 32'd4);
    abort = 1'b1;
    start = 1'b0;
    tick(1);
    check_eq("abort_state", 32'(dbg_state), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_ready", 32'(score_ready), 32'd0);
    check_eq("abort_max", max_score, 32'd0);
    abort = 1'b0;
    tick(2);
    scores = '{0, 7, -1, 7, 100, -100, 99, 100, 3, 2};
    start_run();
    wait_end("re", 200);
    check_eq("re_class", 32'(predicted_class), 32'd4);
    check_eq("re_max", max_score, 32'd100);
    start = 1'b0;
    tick(1);

    // Stray done on an inactive layer; layer 2 done coincides with expiry.
    stray5 = 1'b1;
    dly[2] = TO;
    start_run();
    wait_end("col", 300);
    check_eq("col_error", 32'(error), 32'd0);
    check_eq("col_done", 32'(done), 32'd1);
    check_eq("col_cycles", cycle_count, 32'd46);
    check_eq("col_class", 32'(predicted_class), 32'd4);
    stray5 = 1'b0;
    dly[2] = 3;
    start = 1'b0;
    tick(1);

    // Asynchronous reset during layer 4.
    start_run();
    n = 0;
    while (layer_start != 6'd16 && n < 100) begin tick(1); n++; end
    check_eq("rst4_reached", 32'(layer_start), 32'd16);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_layer_start", 32'(layer_start), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_cycles", cycle_count, 32'd0);
    check_eq("arst_class", 32'(predicted_class), 32'd0);
    start = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(1);
    start_run();
    n = 0;
    while (layer_start == '0 && n < 10) begin tick(1); n++; end
    check_eq("arst_restart_l0", 32'(layer_start), 32'd1);
    wait_end("arst_run", 200);
    check_eq("arst_run_class", 32'(predicted_class), 32'd4);
    start = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end expected end");
    $fatal(1, "simulation time limit");
  end

endmodule
